alu_mc: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mc_if.sv | 25 ++
 rtl/alu_mc_iter.sv | 106 ++++++++++
 rtl/alu_mc.sv | 130 +++++++++++++
 tb/tb_alu_mc.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode classification for the multi-cycle ALU.
// The ALU_MC_DIV_EN macro enables DIVU/REMU; without it those codes decode as unknown.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MUL  = 4'b0011;
    localparam logic [3:0] ALU_DIVU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_REMU = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Opcodes that go through the iterative datapath instead of completing in one cycle
    function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
        return (op == ALU_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bus of the multi-cycle ALU; slave is the ALU, master is the EX-stage driver.
interface alu_mc_if #(parameter int WIDTH = 32);

    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ctrl_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             ovf_o;

    modport slave (
        input  valid_i, src1_i, src2_i, ctrl_i, ready_i,
        output ready_o, valid_o, result_o, zero_o, ovf_o
    );

    modport master (
        output valid_i, src1_i, src2_i, ctrl_i, ready_i,
        input  ready_o, valid_o, result_o, zero_o, ovf_o
    );

endinterface

// File: rtl/alu_mc_iter.sv
// Iterative datapath: shift-add multiplier and (with ALU_MC_DIV_EN) restoring divider.
// result presents the value after the current step so the top can capture it on the done step.
module alu_mc_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
`ifdef ALU_MC_DIV_EN
    input  logic [3:0]       ctrl,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_next;

    assign done     = step && (cnt == CW'(WIDTH - 1));
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (step) begin
            cnt    <= cnt + CW'(1);
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

`ifdef ALU_MC_DIV_EN
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             sel_div;
    logic             sel_rem;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // A zero divisor never fails the trial, giving all-ones quotient and remainder == dividend
    always_comb begin
        r_sh  = {rem, quo[WIDTH-1]};
        trial = r_sh - {1'b0, dvsr};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = r_sh[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            sel_div <= 1'b0;
            sel_rem <= 1'b0;
        end else if (start) begin
            rem     <= '0;
            quo     <= a;
            dvsr    <= b;
            sel_div <= (ctrl == ALU_DIVU);
            sel_rem <= (ctrl == ALU_REMU);
        end else if (step) begin
            rem     <= rem_next;
            quo     <= quo_next;
        end
    end

    always_comb begin
        result = acc_next;
        if (sel_rem) begin
            result = rem_next;
        end else if (sel_div) begin
            result = quo_next;
        end
    end
`else
    assign result = acc_next;
`endif

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: valid/ready FSM, single-cycle logic/arith ops and registered flags.
// Define ALU_MC_DIV_EN to include the DIVU/REMU divider.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    alu_mc_if.slave   bus
);

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             multi;
    logic             start;
    logic             step;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] single_res;
    logic             single_ovf;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;

    assign accept = (state == IDLE) && bus.valid_i;
    assign multi  = is_multicycle(bus.ctrl_i);

    always_comb begin
        sum        = bus.src1_i + bus.src2_i;
        diff       = bus.src1_i - bus.src2_i;
        single_res = '0;
        single_ovf = 1'b0;
        case (bus.ctrl_i)
            ALU_AND: single_res = bus.src1_i & bus.src2_i;
            ALU_OR:  single_res = bus.src1_i | bus.src2_i;
            ALU_NOR: single_res = ~(bus.src1_i | bus.src2_i);
            ALU_ADD: begin
                single_res = sum;
                single_ovf = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                             (sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
            end
            ALU_SUB: begin
                single_res = diff;
                single_ovf = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
                             (diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
            end
            ALU_SLT: single_res = {{(WIDTH-1){1'b0}},
                                   ($signed(bus.src1_i) < $signed(bus.src2_i))};
            default: single_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        start       = 1'b0;
        step        = 1'b0;
        bus.ready_o = 1'b0;
        bus.valid_o = 1'b0;
        case (state)
            IDLE: begin
                bus.ready_o = 1'b1;
                if (bus.valid_i) begin
                    start      = multi;
                    next_state = multi ? BUSY : DONE;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (iter_done) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.valid_o = 1'b1;
                if (bus.ready_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output registers only change on a single-cycle accept or the final iterative step
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else if (accept && !multi) begin
            result_q <= single_res;
            zero_q   <= (single_res == '0);
            ovf_q    <= single_ovf;
        end else if (iter_done) begin
            result_q <= iter_result;
            zero_q   <= (iter_result == '0);
            ovf_q    <= 1'b0;
        end
    end

    assign bus.result_o = result_q;
    assign bus.zero_o   = zero_q;
    assign bus.ovf_o    = ovf_q;

    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk_i),
        .rst    (rst_i),
        .start  (start),
        .step   (step),
`ifdef ALU_MC_DIV_EN
        .ctrl   (bus.ctrl_i),
`endif
        .a      (bus.src1_i),
        .b      (bus.src2_i),
        .done   (iter_done),
        .result (iter_result)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32; divide expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   latency = 0;

    alu_mc_if #(.WIDTH(WIDTH)) bus ();

    alu_mc #(.WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one request, wait for its accept edge, then count edges until valid_o (accept edge = 1)
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.ctrl_i  = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.src1_i  = 32'hDEAD_BEEF;
        bus.src2_i  = 32'h0BAD_F00D;
        latency = 1;
        while (!bus.valid_o && latency < 200) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
    endtask

    task automatic checkOp(input string tag, input logic [31:0] res, input logic zero,
                           input logic ovf, input int lat);
        checkOutput({tag, ".valid"}, {31'd0, bus.valid_o}, 32'd1);
        checkOutput({tag, ".result"}, bus.result_o, res);
        checkOutput({tag, ".zero"}, {31'd0, bus.zero_o}, {31'd0, zero});
        checkOutput({tag, ".ovf"}, {31'd0, bus.ovf_o}, {31'd0, ovf});
        checkOutput({tag, ".latency"}, latency, lat);
        consume();
        checkOutput({tag, ".idle_valid"}, {31'd0, bus.valid_o}, 32'd0);
        checkOutput({tag, ".idle_ready"}, {31'd0, bus.ready_o}, 32'd1);
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.ctrl_i  = 4'b0000;
        bus.src1_i  = '0;
        bus.src2_i  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset.ready", {31'd0, bus.ready_o}, 32'd1);
        checkOutput("reset.valid", {31'd0, bus.valid_o}, 32'd0);
        checkOutput("reset.result", bus.result_o, 32'd0);
        checkOutput("reset.zero", {31'd0, bus.zero_o}, 32'd1);
        checkOutput("reset.ovf", {31'd0, bus.ovf_o}, 32'd0);

        applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        checkOp("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1);
        applyStimulus(ALU_SUB, 32'd5, 32'd5);
        checkOp("sub_zero", 32'd0, 1'b1, 1'b0, 1);
        applyStimulus(ALU_SUB, 32'h8000_0000, 32'd1);
        checkOp("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
        applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        checkOp("slt_neg", 32'd1, 1'b0, 1'b0, 1);
        applyStimulus(ALU_SLT, 32'd1, 32'hFFFF_FFFF);
        checkOp("slt_pos", 32'd0, 1'b1, 1'b0, 1);
        applyStimulus(ALU_NOR, 32'd0, 32'd0);
        checkOp("nor", 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        applyStimulus(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
        checkOp("and", 32'h00F0_1200, 1'b0, 1'b0, 1);
        applyStimulus(ALU_OR, 32'hF000_0001, 32'h0000_1000);
        checkOp("or", 32'hF000_1001, 1'b0, 1'b0, 1);
        applyStimulus(4'b1111, 32'd7, 32'd9);
        checkOp("unknown", 32'd0, 1'b1, 1'b0, 1);

        applyStimulus(ALU_MUL, 32'h0001_0000, 32'h0001_0000);
        checkOp("mul_wrap", 32'd0, 1'b1, 1'b0, 33);
        applyStimulus(ALU_MUL, 32'd1234, 32'd5678);
        checkOp("mul", 32'd7006652, 1'b0, 1'b0, 33);

`ifdef ALU_MC_DIV_EN
        applyStimulus(ALU_DIVU, 32'd100, 32'd7);
        checkOp("divu", 32'd14, 1'b0, 1'b0, 33);
        applyStimulus(ALU_REMU, 32'd100, 32'd7);
        checkOp("remu", 32'd2, 1'b0, 1'b0, 33);
        applyStimulus(ALU_DIVU, 32'h1234_5678, 32'd0);
        checkOp("divu_by0", 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
        applyStimulus(ALU_REMU, 32'd9, 32'd0);
        checkOp("remu_by0", 32'd9, 1'b0, 1'b0, 33);
`else
        applyStimulus(ALU_DIVU, 32'd100, 32'd7);
        checkOp("divu_off", 32'd0, 1'b1, 1'b0, 1);
        applyStimulus(ALU_REMU, 32'd100, 32'd7);
        checkOp("remu_off", 32'd0, 1'b1, 1'b0, 1);
`endif

        // Backpressure: result held for 10 cycles while a stray request is offered
        applyStimulus(ALU_ADD, 32'd3, 32'd4);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                @(negedge clk);
                bus.valid_i = 1'b1;
                bus.ctrl_i  = ALU_SUB;
                bus.src1_i  = 32'd1;
                bus.src2_i  = 32'd9;
                @(posedge clk);
                #1;
                bus.valid_i = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            checkOutput("hold.valid", {31'd0, bus.valid_o}, 32'd1);
            checkOutput("hold.ready", {31'd0, bus.ready_o}, 32'd0);
            checkOutput("hold.result", bus.result_o, 32'd7);
            checkOutput("hold.zero", {31'd0, bus.zero_o}, 32'd0);
        end
        consume();
        checkOutput("hold.after_valid", {31'd0, bus.valid_o}, 32'd0);
        checkOutput("hold.after_ready", {31'd0, bus.ready_o}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("hold.stray_ignored", {31'd0, bus.valid_o}, 32'd0);

        // Reset asserted on the 10th BUSY cycle of a multiply
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.ctrl_i  = ALU_MUL;
        bus.src1_i  = 32'd11;
        bus.src2_i  = 32'd13;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_busy.ready", {31'd0, bus.ready_o}, 32'd1);
        checkOutput("rst_busy.valid", {31'd0, bus.valid_o}, 32'd0);
        checkOutput("rst_busy.result", bus.result_o, 32'd0);
        checkOutput("rst_busy.zero", {31'd0, bus.zero_o}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("rst_busy.no_valid", {31'd0, bus.valid_o}, 32'd0);

        applyStimulus(ALU_ADD, 32'd2, 32'd3);
        checkOp("post_rst_add", 32'd5, 1'b0, 1'b0, 1);
        applyStimulus(ALU_MUL, 32'd3, 32'd7);
        checkOp("post_rst_mul", 32'd21, 1'b0, 1'b0, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
